// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// params / calc_pkg
// Panel geometry defaults and the derived bit-width helpers shared by the
// framebuffer blocks.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package params;
  localparam int PIXEL_WIDTH      = 64;
  localparam int PIXEL_HEIGHT     = 32;
  localparam int PIXEL_HALFHEIGHT = 16;
  localparam int BYTES_PER_PIXEL  = 2;
endpackage

package calc_pkg;
  // Row sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fb_reader_state_t;

  // Bits to select a row inside one subpanel
  function automatic int num_row_bits(input int halfheight);
    return $clog2(halfheight);
  endfunction

  // Bits to select a column
  function automatic int num_column_bits(input int width);
    return $clog2(width);
  endfunction

  // AddressB is {row, column}
  function automatic int num_address_b_bits(input int halfheight, input int width);
    return $clog2(halfheight) + $clog2(width);
  endfunction

  // QB carries every colour byte of every subpanel side by side
  function automatic int num_data_b_bits(input int height, input int halfheight,
                                         input int bytes);
    return (height / halfheight) * bytes * 8;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fb_read_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_read_fifo
// Small synchronous FIFO; the occupancy count feeds the read-credit logic.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module fb_read_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 38
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [DW-1:0]       storage [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                full;
  logic                do_push;
  logic                do_pop;

  // Pointer advance with wrap for non-power-of-two depths
  function automatic logic [PTR_BITS-1:0] bump(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_BITS'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  // Data array: written on push, no reset needed since count gates reads
  always_ff @(posedge clk_in) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit scheme must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk_in) disable iff (!reset_n) !(push && full));

endmodule
`default_nettype wire

// File: rtl/fb_row_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_row_reader
// Issues one AddressB read per column of a requested row, tracks the
// 2-cycle read latency and streams QB words out as valid/ready pixels.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module fb_row_reader
  import calc_pkg::*;
#(
  parameter int PIXEL_WIDTH      = params::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT     = params::PIXEL_HEIGHT,
  parameter int PIXEL_HALFHEIGHT = params::PIXEL_HALFHEIGHT,
  parameter int BYTES_PER_PIXEL  = params::BYTES_PER_PIXEL,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                                clk_in,
  input  logic                                                reset_n,
  input  logic                                                row_start,
  input  logic [num_row_bits(PIXEL_HALFHEIGHT)-1:0]           row_address,
  output logic                                                row_busy,
  output logic                                                row_done,
  output logic [num_address_b_bits(PIXEL_HALFHEIGHT, PIXEL_WIDTH)-1:0] mem_addr_b,
  output logic                                                mem_en_b,
  input  logic [num_data_b_bits(PIXEL_HEIGHT, PIXEL_HALFHEIGHT, BYTES_PER_PIXEL)-1:0] mem_qb,
  output logic [num_data_b_bits(PIXEL_HEIGHT, PIXEL_HALFHEIGHT, BYTES_PER_PIXEL)-1:0] pixel_data,
  output logic [num_column_bits(PIXEL_WIDTH)-1:0]             pixel_column,
  output logic                                                pixel_last,
  output logic                                                pixel_valid,
  input  logic                                                pixel_ready
);

  localparam int ROW_BITS  = num_row_bits(PIXEL_HALFHEIGHT);
  localparam int COL_BITS  = num_column_bits(PIXEL_WIDTH);
  localparam int ADDR_BITS = num_address_b_bits(PIXEL_HALFHEIGHT, PIXEL_WIDTH);
  localparam int DATA_BITS = num_data_b_bits(PIXEL_HEIGHT, PIXEL_HALFHEIGHT, BYTES_PER_PIXEL);
  localparam int CNT_BITS  = $clog2(FIFO_DEPTH + 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PIXEL_WIDTH - 1);

  fb_reader_state_t state;
  fb_reader_state_t state_next;

  logic [ROW_BITS-1:0]           row_q;
  logic [COL_BITS:0]             issue_col;      // MSB set once every column is issued
  logic [ADDR_BITS-1:0]          addr_hold;
  logic [ADDR_BITS-1:0]          issue_addr;
  logic                          stage1_valid;
  logic                          stage2_valid;
  logic [COL_BITS-1:0]           stage1_col;
  logic [COL_BITS-1:0]           stage2_col;
  logic                          done_q;
  logic                          issue;
  logic                          credit_ok;
  logic                          pop;
  logic                          fifo_empty;
  logic [CNT_BITS-1:0]           fifo_count;
  logic [DATA_BITS+COL_BITS-1:0] fifo_head;

  assign issue_addr = {row_q, issue_col[COL_BITS-1:0]};

  // Reads in the latency pipe plus buffered words may never exceed the FIFO
  assign credit_ok = (int'(stage1_valid) + int'(stage2_valid) + int'(fifo_count)) < FIFO_DEPTH;

  assign pixel_valid  = !fifo_empty;
  assign pop          = pixel_valid && pixel_ready;
  assign pixel_data   = pixel_valid ? fifo_head[DATA_BITS+COL_BITS-1:COL_BITS] : '0;
  assign pixel_column = pixel_valid ? fifo_head[COL_BITS-1:0] : '0;
  assign pixel_last   = pixel_valid && (pixel_column == LAST_COL);

  assign mem_en_b   = issue;
  assign mem_addr_b = issue ? issue_addr : addr_hold;
  assign row_busy   = (state != IDLE);
  assign row_done   = done_q;

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and read-issue decision
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (row_start) state_next = ISSUE;
      end
      ISSUE: begin
        issue = credit_ok && !issue_col[COL_BITS];
        if (issue && (issue_col[COL_BITS-1:0] == LAST_COL)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && pixel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row latch, issue column, address hold, latency pipe and done pulse
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      row_q        <= '0;
      issue_col    <= '0;
      addr_hold    <= '0;
      stage1_valid <= 1'b0;
      stage2_valid <= 1'b0;
      stage1_col   <= '0;
      stage2_col   <= '0;
      done_q       <= 1'b0;
    end else begin
      if ((state == IDLE) && row_start) begin
        row_q     <= row_address;
        issue_col <= '0;
      end else if (issue) begin
        issue_col <= issue_col + 1'b1;
        addr_hold <= issue_addr;
      end
      stage1_valid <= issue;
      stage1_col   <= issue_col[COL_BITS-1:0];
      stage2_valid <= stage1_valid;
      stage2_col   <= stage1_col;
      done_q       <= (state == DRAIN) && pop && pixel_last;
    end
  end

  fb_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_BITS + COL_BITS)
  ) u_fifo (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .push      (stage2_valid),
    .push_data ({mem_qb, stage2_col}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fb_row_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_row_reader
// Directed bench for fb_row_reader with a 2-cycle memory model (QB = addr).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fb_row_reader;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        row_start;
  logic [3:0]  row_address;
  logic        row_busy;
  logic        row_done;
  logic [9:0]  mem_addr_b;
  logic        mem_en_b;
  logic [31:0] mem_qb;
  logic [31:0] pixel_data;
  logic [5:0]  pixel_column;
  logic        pixel_last;
  logic        pixel_valid;
  logic        pixel_ready;

  int checks = 0;
  int errors = 0;

  // Per-row observations gathered by collect
  logic [31:0] rx_data [80];
  logic [5:0]  rx_col  [80];
  logic        rx_last [80];
  int rx_n, first_valid_cyc, first_en_cyc, done_cyc, last_cyc, max_out;
  int stall_viol, addr_bad, issued_at20, stall0_cnt;
  logic [9:0] first_addr;
  logic       busy_at_done;

  always #5 clk_in = ~clk_in;

  // Memory model: 2-cycle read latency, data equals the address read
  logic [9:0] m1, m2;
  always @(posedge clk_in) begin
    if (mem_en_b) m1 <= mem_addr_b;
    m2 <= m1;
  end
  assign mem_qb = {22'b0, m2};

  fb_row_reader dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .row_start    (row_start),
    .row_address  (row_address),
    .row_busy     (row_busy),
    .row_done     (row_done),
    .mem_addr_b   (mem_addr_b),
    .mem_en_b     (mem_en_b),
    .mem_qb       (mem_qb),
    .pixel_data   (pixel_data),
    .pixel_column (pixel_column),
    .pixel_last   (pixel_last),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready)
  );

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return !(c >= 4 && c <= 20);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic start_row(input logic [3:0] r);
    @(posedge clk_in); #1;
    row_start   = 1'b1;
    row_address = r;
  endtask

  // Runs one row from cycle 0 (row_start cycle) until row_done, recording observations
  task automatic collect(input int mode, input int inj_cyc, input logic [3:0] inj_row,
                         input bit at_neg);
    int cyc, issued, popped;
    logic [31:0] prev_data;
    logic [5:0]  prev_col;
    bit prev_stall;
    for (int i = 0; i < 80; i++) begin rx_data[i] = '1; rx_col[i] = '1; rx_last[i] = 1'b0; end
    rx_n = 0; first_valid_cyc = -1; first_en_cyc = -1; first_addr = '0; done_cyc = -1;
    last_cyc = -1; max_out = 0; stall_viol = 0; addr_bad = 0; issued_at20 = -1;
    stall0_cnt = 0; busy_at_done = 1'b1;
    issued = 0; popped = 0; prev_stall = 0; prev_data = '0; prev_col = '0; cyc = 0;
    pixel_ready = ready_for(mode, 0);
    if (!at_neg) @(negedge clk_in);
    forever begin
      if (cyc > 0 && row_done) begin
        done_cyc = cyc; busy_at_done = row_busy;
        break;
      end
      if (mem_addr_b >= 10'h0C0 && mem_addr_b <= 10'h0FF) addr_bad++;
      if (mem_en_b) begin
        if (first_en_cyc < 0) begin first_en_cyc = cyc; first_addr = mem_addr_b; end
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_stall && (!pixel_valid || pixel_data !== prev_data || pixel_column !== prev_col))
        stall_viol++;
      if (pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mode == 1 && cyc >= 4 && cyc <= 20 && pixel_valid && pixel_data == 32'h0 &&
          pixel_column == 6'd0) stall0_cnt++;
      if (cyc == 20) issued_at20 = issued;
      if (pixel_valid && pixel_ready) begin
        if (rx_n < 80) begin
          rx_data[rx_n] = pixel_data; rx_col[rx_n] = pixel_column; rx_last[rx_n] = pixel_last;
        end
        rx_n++; popped++;
        if (pixel_last) last_cyc = cyc;
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_data  = pixel_data;
      prev_col   = pixel_column;
      if (cyc >= 2000) break;
      @(posedge clk_in); #1;
      cyc++;
      row_start = (cyc == inj_cyc);
      if (cyc == inj_cyc) row_address = inj_row;
      pixel_ready = ready_for(mode, cyc);
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; row_start = 1'b0; row_address = '0; pixel_ready = 1'b0;
    #3;
    checks++;
    if (pixel_valid !== 1'b0 || pixel_data !== 32'h0 || pixel_last !== 1'b0) begin
      errors++; $display("FAIL reset_pixel: valid=%b data=%h last=%b want 0/0/0",
                         pixel_valid, pixel_data, pixel_last);
    end
    checks++;
    if (row_busy !== 1'b0 || row_done !== 1'b0) begin
      errors++; $display("FAIL reset_row: busy=%b done=%b want 0/0", row_busy, row_done);
    end
    checks++;
    if (mem_en_b !== 1'b0 || mem_addr_b !== 10'h0) begin
      errors++; $display("FAIL reset_mem: en=%b addr=%h want 0/000", mem_en_b, mem_addr_b);
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  task automatic test_row_stream();
    int bad;
    start_row(4'd5);
    collect(0, -1, 4'd0, 1'b0);
    checks++;
    if (first_en_cyc !== 1 || first_addr !== 10'h140) begin
      errors++; $display("FAIL row5_first_read: cyc=%0d addr=%h want 1/140", first_en_cyc, first_addr);
    end
    checks++;
    if (first_valid_cyc !== 4) begin
      errors++; $display("FAIL row5_first_valid: got %0d want 4", first_valid_cyc);
    end
    checks++;
    if (last_cyc !== 67 || done_cyc !== 68) begin
      errors++; $display("FAIL row5_last_done: last=%0d done=%0d want 67/68", last_cyc, done_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++; $display("FAIL row5_busy_at_done: got %b want 0", busy_at_done);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(32'h140 + i) || rx_col[i] !== 6'(i) || rx_last[i] !== (i == 63)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0) begin
      errors++; $display("FAIL row5_words: count=%0d bad=%0d want 64/0", rx_n, bad);
    end
  endtask

  task automatic test_stall();
    int bad;
    start_row(4'd0);
    collect(1, -1, 4'd0, 1'b0);
    checks++;
    if (issued_at20 !== 4) begin
      errors++; $display("FAIL stall_issued: got %0d want 4", issued_at20);
    end
    checks++;
    if (stall0_cnt !== 17) begin
      errors++; $display("FAIL stall_hold_word0: held cycles %0d want 17", stall0_cnt);
    end
    checks++;
    if (stall_viol !== 0 || max_out > 4) begin
      errors++; $display("FAIL stall_stable: viol=%0d max_out=%0d want 0/<=4", stall_viol, max_out);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(i) || rx_col[i] !== 6'(i)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0) begin
      errors++; $display("FAIL stall_words: count=%0d bad=%0d want 64/0", rx_n, bad);
    end
  endtask

  task automatic test_random_ready();
    int bad;
    start_row(4'd15);
    collect(2, -1, 4'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(32'h3C0 + i) || rx_col[i] !== 6'(i) || rx_last[i] !== (i == 63)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0) begin
      errors++; $display("FAIL random_words: count=%0d bad=%0d want 64/0", rx_n, bad);
    end
    checks++;
    if (max_out > 4) begin
      errors++; $display("FAIL random_outstanding: max=%0d want <=4", max_out);
    end
    checks++;
    if (stall_viol !== 0 || done_cyc < 68) begin
      errors++; $display("FAIL random_stall_done: viol=%0d done=%0d want 0/>=68", stall_viol, done_cyc);
    end
  endtask

  task automatic test_ignore_start();
    int bad;
    start_row(4'd2);
    collect(0, 10, 4'd3, 1'b0);
    checks++;
    if (addr_bad !== 0) begin
      errors++; $display("FAIL ignore_addr_range: hits=%0d want 0", addr_bad);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(32'h080 + i) || rx_col[i] !== 6'(i)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0 || done_cyc !== 68) begin
      errors++; $display("FAIL ignore_row2: count=%0d bad=%0d done=%0d want 64/0/68", rx_n, bad, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    start_row(4'd6);
    collect(0, -1, 4'd0, 1'b0);
    checks++;
    if (done_cyc !== 68) begin
      errors++; $display("FAIL b2b_row6_done: got %0d want 68", done_cyc);
    end
    row_start   = 1'b1;
    row_address = 4'd7;
    collect(0, -1, 4'd0, 1'b1);
    checks++;
    if (first_en_cyc !== 1 || first_addr !== 10'h1C0) begin
      errors++; $display("FAIL b2b_first_read: cyc=%0d addr=%h want 1/1c0", first_en_cyc, first_addr);
    end
    checks++;
    if (first_valid_cyc !== 4 || done_cyc !== 68) begin
      errors++; $display("FAIL b2b_timing: valid=%0d done=%0d want 4/68", first_valid_cyc, done_cyc);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(32'h1C0 + i)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0) begin
      errors++; $display("FAIL b2b_words: count=%0d bad=%0d want 64/0", rx_n, bad);
    end
  endtask

  task automatic test_reset_mid_row();
    int bad;
    bit found;
    found = 0;
    pixel_ready = 1'b1;
    start_row(4'd9);
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_in);
      if (pixel_valid && pixel_column == 6'd20) found = 1;
      else begin @(posedge clk_in); #1; row_start = 1'b0; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midreset_reach_col20: found=%0d want 1", found);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pixel_valid !== 1'b0 || pixel_data !== 32'h0 || pixel_column !== 6'h0 || pixel_last !== 1'b0) begin
      errors++; $display("FAIL midreset_pixel: valid=%b data=%h col=%0d last=%b want 0",
                         pixel_valid, pixel_data, pixel_column, pixel_last);
    end
    checks++;
    if (row_busy !== 1'b0 || mem_en_b !== 1'b0 || mem_addr_b !== 10'h0 || row_done !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl: busy=%b en=%b addr=%h done=%b want 0",
                         row_busy, mem_en_b, mem_addr_b, row_done);
    end
    #1;
    reset_n = 1'b1;
    start_row(4'd1);
    collect(0, -1, 4'd0, 1'b0);
    checks++;
    if (rx_data[0] !== 32'h040) begin
      errors++; $display("FAIL midreset_first_word: got %h want 00000040", rx_data[0]);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rx_data[i] !== 32'(32'h040 + i) || rx_col[i] !== 6'(i)) bad++;
    checks++;
    if (rx_n !== 64 || bad !== 0) begin
      errors++; $display("FAIL midreset_words: count=%0d bad=%0d want 64/0", rx_n, bad);
    end
  endtask

  initial begin
    test_reset();
    test_row_stream();
    test_stall();
    test_random_ready();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
